// File: rtl/store_buffer_pkg.sv
// Shared core constants and types for the store buffer; ROB and rename carry SB_IDXW-wide
// store-buffer indices.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 8;
  localparam int unsigned SB_IDXW  = 3;
  localparam int unsigned SB_AW    = 32;
  localparam int unsigned SB_DW    = 32;
  localparam int unsigned SB_SW    = SB_DW / 8;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } sb_drain_state_e;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [SB_SW-1:0] wstrb;
    logic             done;
    logic             cmt;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer. The slave modport is the buffer itself;
// the master modport is the core pipeline and memory port driving it.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic               alloc_en1;
  logic               alloc_en2;
  logic               alloc_rdy;
  logic [SB_IDXW-1:0] alloc_idx1;
  logic [SB_IDXW-1:0] alloc_idx2;
  logic               ex_en;
  logic [SB_IDXW-1:0] ex_idx;
  logic [SB_AW-1:0]   ex_addr;
  logic [SB_DW-1:0]   ex_data;
  logic [SB_SW-1:0]   ex_wstrb;
  logic               write1;
  logic               write2;
  logic               flush;
  logic               mem_req;
  logic [SB_AW-1:0]   mem_addr;
  logic [SB_DW-1:0]   mem_data;
  logic [SB_SW-1:0]   mem_wstrb;
  logic               mem_ack;
  logic               empty;
  logic [SB_IDXW:0]   count;

  modport slave (
    input  alloc_en1, alloc_en2, ex_en, ex_idx, ex_addr, ex_data, ex_wstrb,
    input  write1, write2, flush, mem_ack,
    output alloc_rdy, alloc_idx1, alloc_idx2, mem_req, mem_addr, mem_data, mem_wstrb,
    output empty, count
  );

  modport master (
    output alloc_en1, alloc_en2, ex_en, ex_idx, ex_addr, ex_data, ex_wstrb,
    output write1, write2, flush, mem_ack,
    input  alloc_rdy, alloc_idx1, alloc_idx2, mem_req, mem_addr, mem_data, mem_wstrb,
    input  empty, count
  );

endinterface

// File: rtl/store_buffer.sv
// In-order circular store buffer: allocate at rename, fill at execute, mark at commit, drain the
// oldest committed entry over req/ack. Flush discards everything younger than the commit pointer.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  store_buffer_if.slave sb
);

  localparam int unsigned D  = SB_DEPTH;
  localparam int unsigned IW = SB_IDXW;

  typedef logic [IW:0] ptr_t;

  ptr_t            r_head, r_cptr, r_tail;
  sb_entry_t       r_ent [D];
  sb_drain_state_e r_state;
  logic            r_mem_req;
  logic [SB_AW-1:0] r_mem_addr;
  logic [SB_DW-1:0] r_mem_data;
  logic [SB_SW-1:0] r_mem_wstrb;

  ptr_t          w_count, w_uncmt, w_n_alloc, w_m_req, w_m, w_cptr_nxt, w_discard;
  logic          w_alloc_rdy, w_do_alloc, w_ex_ok, w_ack;
  logic [IW-1:0] w_ex_off, w_head_idx, w_next_idx;
  logic [IW-1:0] w_off_a [D];
  logic [IW-1:0] w_off_c [D];
  logic [IW-1:0] w_off_f [D];
  logic [D-1:0]  w_alloc_hit, w_cmt_hit, w_flush_clr, w_cmt_bad;

  assign w_count     = r_tail - r_head;
  assign w_uncmt     = r_tail - r_cptr;
  assign w_alloc_rdy = (w_count <= ptr_t'(D - 2));
  assign w_do_alloc  = w_alloc_rdy && !sb.flush;
  assign w_n_alloc   = ptr_t'(sb.alloc_en1) + ptr_t'(sb.alloc_en2);
  assign w_m_req     = ptr_t'(sb.write1) + ptr_t'(sb.write2);
  // An over-commit is clamped to the entries that actually exist.
  assign w_m         = (w_m_req > w_uncmt) ? w_uncmt : w_m_req;
  assign w_cptr_nxt  = r_cptr + w_m;
  assign w_discard   = r_tail - w_cptr_nxt;
  assign w_ex_off    = sb.ex_idx - r_cptr[IW-1:0];
  assign w_ex_ok     = sb.ex_en && ({1'b0, w_ex_off} < w_uncmt) &&
                       !(sb.flush && ({1'b0, w_ex_off} >= w_m));
  assign w_ack       = (r_state == StReq) && sb.mem_ack;
  assign w_head_idx  = r_head[IW-1:0];
  assign w_next_idx  = w_head_idx + IW'(1);

  always_comb begin
    for (int i = 0; i < D; i++) begin
      w_off_a[i]     = IW'(i) - r_tail[IW-1:0];
      w_off_c[i]     = IW'(i) - r_cptr[IW-1:0];
      w_off_f[i]     = IW'(i) - w_cptr_nxt[IW-1:0];
      w_alloc_hit[i] = w_do_alloc && ({1'b0, w_off_a[i]} < w_n_alloc);
      w_cmt_hit[i]   = {1'b0, w_off_c[i]} < w_m;
      w_flush_clr[i] = sb.flush && ({1'b0, w_off_f[i]} < w_discard);
      w_cmt_bad[i]   = w_cmt_hit[i] && !r_ent[i].done;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_cptr <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + ptr_t'(w_ack);
      r_cptr <= w_cptr_nxt;
      if (sb.flush)        r_tail <= w_cptr_nxt;
      else if (w_do_alloc) r_tail <= r_tail + w_n_alloc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < D; i++) begin
        if (w_ack && (IW'(i) == w_head_idx)) begin
          r_ent[i] <= '0;
        end else begin
          if (w_alloc_hit[i] || w_flush_clr[i]) begin
            r_ent[i].done <= 1'b0;
            r_ent[i].cmt  <= 1'b0;
          end
          if (w_ex_ok && (IW'(i) == sb.ex_idx)) begin
            r_ent[i].addr  <= sb.ex_addr;
            r_ent[i].data  <= sb.ex_data;
            r_ent[i].wstrb <= sb.ex_wstrb;
            r_ent[i].done  <= 1'b1;
          end
          if (w_cmt_hit[i]) r_ent[i].cmt <= 1'b1;
        end
      end
    end
  end

  // Drain FSM: the request fields are captured once and held until the ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_wstrb <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if ((r_head != r_cptr) && r_ent[w_head_idx].done) begin
            r_state     <= StReq;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= r_ent[w_head_idx].addr;
            r_mem_data  <= r_ent[w_head_idx].data;
            r_mem_wstrb <= r_ent[w_head_idx].wstrb;
          end
        end
        StReq: begin
          if (sb.mem_ack) begin
            if (r_ent[w_next_idx].cmt && r_ent[w_next_idx].done) begin
              r_mem_addr  <= r_ent[w_next_idx].addr;
              r_mem_data  <= r_ent[w_next_idx].data;
              r_mem_wstrb <= r_ent[w_next_idx].wstrb;
            end else begin
              r_state   <= StIdle;
              r_mem_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign sb.alloc_rdy  = w_alloc_rdy;
  assign sb.alloc_idx1 = r_tail[IW-1:0];
  assign sb.alloc_idx2 = sb.alloc_en1 ? (r_tail[IW-1:0] + IW'(1)) : r_tail[IW-1:0];
  assign sb.count      = w_count;
  assign sb.empty      = (r_tail == r_head);
  assign sb.mem_req    = r_mem_req;
  assign sb.mem_addr   = r_mem_addr;
  assign sb.mem_data   = r_mem_data;
  assign sb.mem_wstrb  = r_mem_wstrb;

  a_alloc_legal: assert property (@(posedge clk) disable iff (rst)
    (sb.alloc_en1 || sb.alloc_en2) |-> w_alloc_rdy);
  a_ex_in_range: assert property (@(posedge clk) disable iff (rst)
    sb.ex_en |-> ({1'b0, w_ex_off} < w_uncmt));
  a_cmt_in_range: assert property (@(posedge clk) disable iff (rst) w_m_req <= w_uncmt);
  a_cmt_done: assert property (@(posedge clk) disable iff (rst) w_cmt_bad == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, randomized traffic against a
// pointer/array reference model, and hand-written flush, wrap and reset sequences.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int D = SB_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: unbounded sequence numbers, entries addressed modulo D.
  int          mh, mc, mt;
  bit          m_done [D];
  logic [31:0] m_a [D];
  logic [31:0] m_d [D];
  logic [3:0]  m_s [D];
  bit          m_req;
  logic [31:0] m_ma, m_md;
  logic [3:0]  m_ms;

  typedef struct {
    bit a1, a2, ex;
    logic [2:0] exi;
    logic [31:0] ea, ed;
    logic [3:0] es;
    bit w1, w2, fl, ack;
    int e_idx1, e_idx2, e_cnt;
    bit e_req;
    logic [31:0] e_addr, e_data;
    logic [3:0] e_strb;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mh = 0; mc = 0; mt = 0; m_req = 0;
    m_ma = '0; m_md = '0; m_ms = '0;
    for (int i = 0; i < D; i++) begin
      m_done[i] = 0; m_a[i] = '0; m_d[i] = '0; m_s[i] = '0;
    end
  endtask

  task automatic m_load(input int p);
    m_ma = m_a[p % D]; m_md = m_d[p % D]; m_ms = m_s[p % D];
  endtask

  task automatic m_step();
    int cnt, un, m, nh, nc, nt, n, off;
    bit rdy, drained;
    cnt = mt - mh;
    rdy = (D - cnt) >= 2;
    un  = mt - mc;
    m   = int'(sb_if.write1) + int'(sb_if.write2);
    if (m > un) m = un;
    nh = mh;
    drained = 0;
    if (m_req) begin
      if (sb_if.mem_ack) begin
        drained = 1;
        nh = mh + 1;
        if (nh < mc && m_done[nh % D]) m_load(nh);
        else m_req = 0;
      end
    end else if (mh != mc && m_done[mh % D]) begin
      m_req = 1;
      m_load(mh);
    end
    if (drained) m_done[mh % D] = 0;
    nc = mc + m;
    if (sb_if.ex_en) begin
      off = (int'(sb_if.ex_idx) - (mc % D) + D) % D;
      if (off < un && !(sb_if.flush && off >= m)) begin
        m_a[sb_if.ex_idx] = sb_if.ex_addr;
        m_d[sb_if.ex_idx] = sb_if.ex_data;
        m_s[sb_if.ex_idx] = sb_if.ex_wstrb;
        m_done[sb_if.ex_idx] = 1;
      end
    end
    nt = mt;
    if (sb_if.flush) begin
      for (int p = nc; p < mt; p++) m_done[p % D] = 0;
      nt = nc;
    end else if (rdy) begin
      n = int'(sb_if.alloc_en1) + int'(sb_if.alloc_en2);
      for (int k = 0; k < n; k++) m_done[(mt + k) % D] = 0;
      nt = mt + n;
    end
    mh = nh; mc = nc; mt = nt;
  endtask

  task automatic drive_idle();
    sb_if.alloc_en1 = 0; sb_if.alloc_en2 = 0; sb_if.ex_en = 0; sb_if.ex_idx = '0;
    sb_if.ex_addr = '0; sb_if.ex_data = '0; sb_if.ex_wstrb = '0;
    sb_if.write1 = 0; sb_if.write2 = 0; sb_if.flush = 0; sb_if.mem_ack = 0;
  endtask

  task automatic post_check();
    chk("count", sb_if.count, mt - mh);
    chk("empty", sb_if.empty, mt == mh);
    chk("alloc_rdy", sb_if.alloc_rdy, (D - (mt - mh)) >= 2);
    chk("mem_req", sb_if.mem_req, m_req);
    if (m_req) begin
      chk("mem_addr", sb_if.mem_addr, m_ma);
      chk("mem_data", sb_if.mem_data, m_md);
      chk("mem_wstrb", sb_if.mem_wstrb, m_ms);
    end
  endtask

  // Called a little after a rising edge with inputs already driven; returns just after the next.
  task automatic tick();
    #3;
    chk("alloc_idx1", sb_if.alloc_idx1, mt % D);
    chk("alloc_idx2", sb_if.alloc_idx2, (mt + int'(sb_if.alloc_en1)) % D);
    m_step();
    @(posedge clk);
    #1;
    post_check();
  endtask

  task automatic do_reset();
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", sb_if.mem_req, 0);
    chk("rst_count", sb_if.count, 0);
    chk("rst_empty", sb_if.empty, 1);
    chk("rst_alloc_rdy", sb_if.alloc_rdy, 1);
    chk("rst_alloc_idx", {sb_if.alloc_idx1, sb_if.alloc_idx2}, 0);
    chk("rst_mem_addr", sb_if.mem_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic rand_cycle();
    int un, avail, m, off;
    drive_idle();
    un = mt - mc;
    avail = 0;
    while (avail < 2 && avail < un && m_done[(mc + avail) % D]) avail++;
    m = int'($urandom_range(avail, 0));
    if (m == 2) begin
      sb_if.write1 = 1; sb_if.write2 = 1;
    end else if (m == 1) begin
      if ($urandom % 2 == 0) sb_if.write1 = 1;
      else sb_if.write2 = 1;
    end
    sb_if.flush = ($urandom % 20 == 0);
    if ((D - (mt - mh)) >= 2 && ($urandom % 3 != 0)) begin
      sb_if.alloc_en1 = 1'($urandom);
      sb_if.alloc_en2 = 1'($urandom);
    end
    if (un - m > 0 && ($urandom % 2 == 0)) begin
      off = m + int'($urandom % (un - m));
      sb_if.ex_en    = 1;
      sb_if.ex_idx   = 3'((mc + off) % D);
      sb_if.ex_addr  = $urandom;
      sb_if.ex_data  = $urandom;
      sb_if.ex_wstrb = 4'($urandom);
    end
    sb_if.mem_ack = 1'($urandom);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int beats, first, last, cyc, drains;
    bit seen7;
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2, 2, 2, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 1, 1, 32'h104, 32'h11223344, 4'h3, 1, 0, 0, 0, 2, 2, 2, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 1, 32'h100, 32'hDEADBEEF, 4'hF};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 1, 32'h100, 32'hDEADBEEF, 4'hF};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 1, 32'h100, 32'hDEADBEEF, 4'hF};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 2, 1, 32'h100, 32'hDEADBEEF, 4'hF};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 2, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 1, 1, 32'h104, 32'h11223344, 4'h3};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0};

    do_reset();

    for (int i = 0; i < 11; i++) begin
      sb_if.alloc_en1 = tbl[i].a1; sb_if.alloc_en2 = tbl[i].a2;
      sb_if.ex_en = tbl[i].ex; sb_if.ex_idx = tbl[i].exi;
      sb_if.ex_addr = tbl[i].ea; sb_if.ex_data = tbl[i].ed; sb_if.ex_wstrb = tbl[i].es;
      sb_if.write1 = tbl[i].w1; sb_if.write2 = tbl[i].w2;
      sb_if.flush = tbl[i].fl; sb_if.mem_ack = tbl[i].ack;
      #1;
      chk("tbl_idx1", sb_if.alloc_idx1, tbl[i].e_idx1);
      chk("tbl_idx2", sb_if.alloc_idx2, tbl[i].e_idx2);
      tick();
      chk("tbl_count", sb_if.count, tbl[i].e_cnt);
      chk("tbl_req", sb_if.mem_req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk("tbl_addr", sb_if.mem_addr, tbl[i].e_addr);
        chk("tbl_data", sb_if.mem_data, tbl[i].e_data);
        chk("tbl_strb", sb_if.mem_wstrb, tbl[i].e_strb);
      end
    end

    for (int i = 0; i < 600; i++) rand_cycle();

    // Fill to full, then drain everything back-to-back across the wrap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      sb_if.alloc_en1 = 1; sb_if.alloc_en2 = 1;
      tick();
    end
    chk("full_count", sb_if.count, 8);
    chk("full_rdy", sb_if.alloc_rdy, 0);
    for (int i = 0; i < D; i++) begin
      drive_idle();
      sb_if.ex_en = 1; sb_if.ex_idx = 3'(i);
      sb_if.ex_addr = 32'h2000 + 32'(i * 4); sb_if.ex_data = $urandom; sb_if.ex_wstrb = 4'hF;
      tick();
    end
    beats = 0; first = -1; last = -1; seen7 = 0;
    for (cyc = 0; cyc < 30 && !(cyc >= 4 && sb_if.empty); cyc++) begin
      drive_idle();
      sb_if.mem_ack = 1;
      if (cyc < 4) begin
        sb_if.write1 = 1; sb_if.write2 = 1;
      end
      tick();
      if (sb_if.mem_req) begin
        beats++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (sb_if.count == 7) begin
        seen7 = 1;
        chk("count7_rdy", sb_if.alloc_rdy, 0);
      end
    end
    chk("saw_count7", seen7, 1);
    chk("drain_beats", beats, 8);
    chk("drain_span", last - first + 1, 8);
    chk("wrap_empty", sb_if.empty, 1);
    chk("wrap_idx1", sb_if.alloc_idx1, 0);

    // Allocate 4, execute 4, commit 2, flush: 2 survive and drain, the rest are reused.
    drive_idle();
    sb_if.alloc_en1 = 1; sb_if.alloc_en2 = 1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      sb_if.ex_en = 1; sb_if.ex_idx = 3'(i);
      sb_if.ex_addr = 32'h3000 + 32'(i); sb_if.ex_data = $urandom; sb_if.ex_wstrb = 4'h1;
      tick();
    end
    drive_idle();
    sb_if.write1 = 1; sb_if.write2 = 1;
    tick();
    drive_idle();
    sb_if.flush = 1;
    tick();
    drive_idle();
    chk("flush_count", sb_if.count, 2);
    #1;
    chk("flush_tail_idx", sb_if.alloc_idx1, 2);
    drains = 0;
    for (cyc = 0; cyc < 20 && !sb_if.empty; cyc++) begin
      drive_idle();
      sb_if.mem_ack = 1;
      #1;
      if (sb_if.mem_req) drains++;
      tick();
    end
    chk("flush_drains", drains, 2);
    chk("flush_empty", sb_if.empty, 1);
    drive_idle();
    sb_if.alloc_en1 = 1; sb_if.alloc_en2 = 1;
    #1;
    chk("realloc_idx1", sb_if.alloc_idx1, 2);
    chk("realloc_idx2", sb_if.alloc_idx2, 3);
    tick();

    // Flush with a same-cycle commit and allocation.
    drive_idle();
    sb_if.ex_en = 1; sb_if.ex_idx = 3'd2;
    sb_if.ex_addr = 32'h4444; sb_if.ex_data = 32'hCAFEF00D; sb_if.ex_wstrb = 4'hC;
    tick();
    drive_idle();
    sb_if.write1 = 1; sb_if.alloc_en1 = 1; sb_if.flush = 1;
    tick();
    drive_idle();
    chk("sameflush_count", sb_if.count, 1);
    #1;
    chk("sameflush_tail", sb_if.alloc_idx1, 3);
    for (cyc = 0; cyc < 20 && !sb_if.empty; cyc++) begin
      drive_idle();
      sb_if.mem_ack = 1;
      tick();
    end
    chk("sameflush_empty", sb_if.empty, 1);

    // Reset while a drain request is outstanding.
    drive_idle();
    sb_if.alloc_en1 = 1;
    tick();
    drive_idle();
    sb_if.ex_en = 1; sb_if.ex_idx = 3'd3; sb_if.ex_addr = 32'h5555; sb_if.ex_data = 32'h1;
    sb_if.ex_wstrb = 4'hF;
    tick();
    drive_idle();
    sb_if.write1 = 1;
    tick();
    for (cyc = 0; cyc < 5 && !sb_if.mem_req; cyc++) begin
      drive_idle();
      tick();
    end
    chk("pre_rst_req", sb_if.mem_req, 1);
    do_reset();
    drive_idle();
    sb_if.mem_ack = 1;
    tick();
    chk("post_rst_count", sb_if.count, 0);
    chk("post_rst_req", sb_if.mem_req, 0);
    drive_idle();
    #1;
    chk("post_rst_idx1", sb_if.alloc_idx1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
